// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - shared op/state types and start decode for the multiply/divide unit.
// Optional feature macro: MD_MADD_EN (enables the MADD/MADDU/MSUB/MSUBU family).
package md_pkg;

    typedef enum logic [3:0] {
        NONE  = 4'd0,
        MULT  = 4'd1,
        MULTU = 4'd2,
        DIV   = 4'd3,
        DIVU  = 4'd4,
        MTHI  = 4'd5,
        MTLO  = 4'd6,
        MFHI  = 4'd7,
        MFLO  = 4'd8,
        MADD  = 4'd9,
        MADDU = 4'd10,
        MSUB  = 4'd11,
        MSUBU = 4'd12
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } md_state_e;

    function automatic logic isMdStart(md_op_e op);
        case (op)
            MULT, MULTU, DIV, DIVU: return 1'b1;
`ifdef MD_MADD_EN
            MADD, MADDU, MSUB, MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic isDivOp(md_op_e op);
        return (op == DIV) || (op == DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// rtl/md_calc.sv - combinational 64-bit product / quotient-remainder / accumulate generator.
module md_calc
    import md_pkg::*;
(
    input  md_op_e      op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [63:0] acc_i,
    output logic [63:0] res_o,
    output logic        div_zero_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] quo_u;
    logic [31:0] rem_u;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        signed_div;

    always_comb begin
        prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
        prod_u = {32'd0, a_i} * {32'd0, b_i};

        // Signed division works on magnitudes so truncation is toward zero
        // and the remainder follows the dividend's sign.
        signed_div = (op_i == DIV);
        mag_a      = (signed_div && a_i[31]) ? (32'd0 - a_i) : a_i;
        mag_b      = (signed_div && b_i[31]) ? (32'd0 - b_i) : b_i;
        div_zero_o = (b_i == 32'd0);
        quo_u      = div_zero_o ? 32'd0 : (mag_a / mag_b);
        rem_u      = div_zero_o ? 32'd0 : (mag_a % mag_b);
        quo        = (signed_div && (a_i[31] ^ b_i[31])) ? (32'd0 - quo_u) : quo_u;
        rem        = (signed_div && a_i[31]) ? (32'd0 - rem_u) : rem_u;

        case (op_i)
            MULT:       res_o = prod_s;
            MULTU:      res_o = prod_u;
            DIV, DIVU:  res_o = {rem, quo};
            MADD:       res_o = acc_i + prod_s;
            MADDU:      res_o = acc_i + prod_u;
            MSUB:       res_o = acc_i - prod_s;
            MSUBU:      res_o = acc_i - prod_u;
            default:    res_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// rtl/md_unit.sv - EX-stage multiply/divide unit holding HI/LO with fixed multi-cycle latency.
// Optional feature macro: MD_MADD_EN (decoded through md_pkg::isMdStart).
module md_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  md_op_e      mdOp,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] mdOut_E
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    md_state_e   state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] tmp_hi_q, tmp_hi_d;
    logic [31:0] tmp_lo_q, tmp_lo_d;
    logic        no_write_q, no_write_d;

    logic [63:0] calc_res;
    logic        calc_div_zero;

    md_calc u_calc (
        .op_i       (mdOp),
        .a_i        (rs_E),
        .b_i        (rt_E),
        .acc_i      ({hi_q, lo_q}),
        .res_o      (calc_res),
        .div_zero_o (calc_div_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
            tmp_hi_q   <= 32'd0;
            tmp_lo_q   <= 32'd0;
            no_write_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            tmp_hi_q   <= tmp_hi_d;
            tmp_lo_q   <= tmp_lo_d;
            no_write_q <= no_write_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        tmp_hi_d   = tmp_hi_q;
        tmp_lo_d   = tmp_lo_q;
        no_write_d = no_write_q;

        case (state_q)
            S_IDLE: begin
                if (!flush) begin
                    if (start && isMdStart(mdOp)) begin
                        tmp_hi_d   = calc_res[63:32];
                        tmp_lo_d   = calc_res[31:0];
                        no_write_d = isDivOp(mdOp) && calc_div_zero;
                        cnt_d      = isDivOp(mdOp) ? DIV_LOAD : MULT_LOAD;
                        state_d    = isDivOp(mdOp) ? S_DIV : S_MUL;
                    end else if (mdOp == MTHI) begin
                        hi_d = rs_E;
                    end else if (mdOp == MTLO) begin
                        lo_d = rs_E;
                    end
                end
            end
            S_MUL, S_DIV: begin
                // In-flight ops ignore start and flush: they belong to an older instruction.
                if (cnt_q == 4'd0) begin
                    if (!no_write_q) begin
                        hi_d = tmp_hi_q;
                        lo_d = tmp_lo_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign mdOut_E = (mdOp == MFHI) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - directed plus randomized checks of md_unit against an arithmetic HI/LO model.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    md_op_e      mdOp;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        flush;
    logic        busy;
    logic [31:0] mdOut_E;

    int tests = 0;
    int fails = 0;

    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .mdOp    (mdOp),
        .rs_E    (rs_E),
        .rt_E    (rt_E),
        .flush   (flush),
        .busy    (busy),
        .mdOut_E (mdOut_E)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_hilo(input string tag);
        md_op_e saved;
        saved = mdOp;
        mdOp = MFHI;
        #1;
        chk({tag, "_hi"}, mdOut_E, m_hi);
        mdOp = MFLO;
        #1;
        chk({tag, "_lo"}, mdOut_E, m_lo);
        mdOp = saved;
    endtask

    function automatic bit madd_enabled();
`ifdef MD_MADD_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_cycles(input md_op_e op);
        case (op)
            MULT, MULTU:               return 5;
            DIV, DIVU:                 return 10;
            MADD, MADDU, MSUB, MSUBU:  return madd_enabled() ? 5 : 0;
            default:                   return 0;
        endcase
    endfunction

    // Reference: straight 64-bit integer arithmetic on the architectural HI/LO.
    task automatic model_op(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r;
        longint unsigned ua, ub, p, acc;
        logic [63:0]     res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = 64'(a);
        ub  = 64'(b);
        acc = {m_hi, m_lo};
        res = {m_hi, m_lo};
        case (op)
            MULT:  res = 64'(sa * sb);
            MULTU: res = ua * ub;
            DIV: if (b != 0) begin
                q = sa / sb;
                r = sa % sb;
                res = {r[31:0], q[31:0]};
            end
            DIVU: if (b != 0) begin
                p = ua / ub;
                acc = ua % ub;
                res = {acc[31:0], p[31:0]};
            end
            MTHI: res = {a, m_lo};
            MTLO: res = {m_hi, a};
            MADD:  if (madd_enabled()) res = acc + 64'(sa * sb);
            MADDU: if (madd_enabled()) res = acc + ua * ub;
            MSUB:  if (madd_enabled()) res = acc - 64'(sa * sb);
            MSUBU: if (madd_enabled()) res = acc - ua * ub;
            default: ;
        endcase
        m_hi = res[63:32];
        m_lo = res[31:0];
    endtask

    // Issue one op; disturb = 1 pulses flush, 2 pulses a stray start, in busy cycle 2.
    task automatic run_op(input string tag, input md_op_e op, input logic [31:0] a,
                          input logic [31:0] b, input int disturb);
        int n;
        start = isMdStart(op) || (op == MADD) || (op == MADDU) || (op == MSUB) || (op == MSUBU);
        mdOp  = op;
        rs_E  = a;
        rt_E  = b;
        tick();
        start = 1'b0;
        mdOp  = NONE;
        n = 0;
        while (busy && n < 40) begin
            n++;
            if (n == 2 && disturb == 1) flush = 1'b1;
            if (n == 2 && disturb == 2) begin
                start = 1'b1;
                mdOp  = DIV;
                rs_E  = 32'h1234;
                rt_E  = 32'h7;
            end
            tick();
            flush = 1'b0;
            start = 1'b0;
            mdOp  = NONE;
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'(exp_cycles(op)));
        model_op(op, a, b);
        chk_hilo(tag);
    endtask

    task automatic mt(input md_op_e op, input logic [31:0] v);
        mdOp = op;
        rs_E = v;
        tick();
        mdOp = NONE;
        model_op(op, v, 32'd0);
    endtask

    initial begin
        int          k;
        md_op_e      rop;
        logic [31:0] ra, rb;
        string       tg;

        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        mdOp  = NONE;
        rs_E  = 32'd0;
        rt_E  = 32'd0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", 32'(busy), 32'd0);
        chk_hilo("reset");

        run_op("mult_neg2x3", MULT, 32'hFFFF_FFFE, 32'd3, 0);
        chk("mult_neg2x3_const_lo", mdOut_E, 32'hFFFF_FFFA);

        run_op("divu_7_2", DIVU, 32'd7, 32'd2, 0);
        run_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'd2, 0);
        mdOp = MFHI;
        #1;
        chk("div_m7_2_const_hi", mdOut_E, 32'hFFFF_FFFF);
        mdOp = NONE;

        mt(MTHI, 32'h11);
        mt(MTLO, 32'h22);
        chk_hilo("mt_preset");
        run_op("div_by_zero", DIV, 32'd100, 32'd0, 0);

        // Flushed start and flushed MTLO must both be dropped.
        flush = 1'b1;
        start = 1'b1;
        mdOp  = MULT;
        rs_E  = 32'd9;
        rt_E  = 32'd9;
        tick();
        start = 1'b0;
        chk("flush_start_busy", 32'(busy), 32'd0);
        mdOp = MTLO;
        rs_E = 32'h5;
        tick();
        flush = 1'b0;
        mdOp  = NONE;
        tick();
        chk("flush_start_busy_late", 32'(busy), 32'd0);
        chk_hilo("flush_ignored");

        run_op("flush_inflight", MULTU, 32'hDEAD_BEEF, 32'h1000, 1);
        run_op("start_while_busy", MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2);

        // Asynchronous reset in the middle of a divide.
        start = 1'b1;
        mdOp  = DIV;
        rs_E  = 32'd1000;
        rt_E  = 32'd7;
        tick();
        start = 1'b0;
        mdOp  = NONE;
        tick();
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_busy", 32'(busy), 32'd0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk_hilo("async_reset");
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_busy", 32'(busy), 32'd0);
        run_op("mult_2x3", MULT, 32'd2, 32'd3, 0);

        mt(MTHI, 32'h0);
        mt(MTLO, 32'hFFFF_FFFF);
        run_op("maddu_1x1", MADDU, 32'd1, 32'd1, 0);
        run_op("msub_3x4", MSUB, 32'd3, 32'd4, 0);

        for (k = 0; k < 24; k++) begin
            case ($urandom_range(0, 9))
                0: rop = MULT;
                1: rop = MULTU;
                2: rop = DIV;
                3: rop = DIVU;
                4: rop = MTHI;
                5: rop = MTLO;
                6: rop = MADD;
                7: rop = MADDU;
                8: rop = MSUB;
                default: rop = MSUBU;
            endcase
            ra = $urandom();
            rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
            if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
            if (rop == DIV && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
            tg = $sformatf("rnd%0d_%s", k, rop.name());
            if (rop == MTHI || rop == MTLO) begin
                mt(rop, ra);
                chk_hilo(tg);
            end else begin
                run_op(tg, rop, ra, rb, 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
